// File: rtl/bus_arbiter_if.sv
// Request/grant bundle for the four bus masters plus the shared address strobe.
// The arbiter uses the master modport (it drives the grants); requesters use slave.
interface bus_arbiter_if;
  logic       m0_req_n;
  logic       m1_req_n;
  logic       m2_req_n;
  logic       m3_req_n;
  logic       s_as_n;
  logic       m0_grnt_n;
  logic       m1_grnt_n;
  logic       m2_grnt_n;
  logic       m3_grnt_n;
  logic [1:0] owner;

  modport master (
    input  m0_req_n, m1_req_n, m2_req_n, m3_req_n, s_as_n,
    output m0_grnt_n, m1_grnt_n, m2_grnt_n, m3_grnt_n, owner
  );

  modport slave (
    output m0_req_n, m1_req_n, m2_req_n, m3_req_n, s_as_n,
    input  m0_grnt_n, m1_grnt_n, m2_grnt_n, m3_grnt_n, owner
  );
endinterface

// File: rtl/bus_arbiter.sv
// Round-robin 4-master bus arbiter with parked grant and optional hold-limit preemption.
// Latency: 1 clock request/release to grant; no backpressure, preemption waits for s_as_n high.
module bus_arbiter #(
  parameter int unsigned HOLD_MAX = 16
) (
  input  logic          clk,
  input  logic          reset,
  bus_arbiter_if.master bus
);

  localparam logic [7:0] HOLD_LIM   = 8'(HOLD_MAX);
  localparam bit         PREEMPT_EN = (HOLD_MAX != 0);

  logic [1:0] owner_q;
  logic [1:0] owner_nxt;
  logic [7:0] hold_cnt_q;
  logic [7:0] hold_cnt_nxt;
  logic [3:0] grnt_n_q;
  logic [3:0] req;
  logic [1:0] rr_next;
  logic       own_req;
  logic       other_req;

  assign req       = ~{bus.m3_req_n, bus.m2_req_n, bus.m1_req_n, bus.m0_req_n};
  assign own_req   = req[owner_q];
  assign other_req = |(req & ~(4'b0001 << owner_q));

  // Scan farthest-first so the nearest requester in rotation order wins.
  always_comb begin
    rr_next = owner_q;
    for (int i = 3; i >= 1; i--) begin
      if (req[owner_q + 2'(i)]) begin
        rr_next = owner_q + 2'(i);
      end
    end
  end

  always_comb begin
    owner_nxt    = owner_q;
    hold_cnt_nxt = '0;
    if (PREEMPT_EN && own_req && (hold_cnt_q == HOLD_LIM) && other_req && bus.s_as_n) begin
      owner_nxt = rr_next;
    end else if (own_req) begin
      hold_cnt_nxt = (hold_cnt_q == HOLD_LIM) ? hold_cnt_q : hold_cnt_q + 8'd1;
    end else if (other_req) begin
      owner_nxt = rr_next;
    end
  end

  // Grants decode the next owner so they change on the same edge as owner.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      owner_q    <= 2'd0;
      hold_cnt_q <= 8'd0;
      grnt_n_q   <= 4'b1110;
    end else begin
      owner_q    <= owner_nxt;
      hold_cnt_q <= hold_cnt_nxt;
      grnt_n_q   <= ~(4'b0001 << owner_nxt);
    end
  end

  assign bus.m0_grnt_n = grnt_n_q[0];
  assign bus.m1_grnt_n = grnt_n_q[1];
  assign bus.m2_grnt_n = grnt_n_q[2];
  assign bus.m3_grnt_n = grnt_n_q[3];
  assign bus.owner     = owner_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// Three arbiters (HOLD_MAX 4, 0, 16) share one stimulus stream and are compared
// each cycle against a rule-level reference model; directed phases follow the test plan.
module tb_bus_arbiter;
  logic       clk;
  logic       reset;
  logic [3:0] req_n;
  logic       as_n;

  bus_arbiter_if i_h4 ();
  bus_arbiter_if i_h0 ();
  bus_arbiter_if i_h16 ();

  bus_arbiter #(.HOLD_MAX(4)) u_h4  (.clk(clk), .reset(reset), .bus(i_h4));
  bus_arbiter #(.HOLD_MAX(0)) u_h0  (.clk(clk), .reset(reset), .bus(i_h0));
  bus_arbiter                 u_h16 (.clk(clk), .reset(reset), .bus(i_h16));

  assign {i_h4.m3_req_n, i_h4.m2_req_n, i_h4.m1_req_n, i_h4.m0_req_n}     = req_n;
  assign {i_h0.m3_req_n, i_h0.m2_req_n, i_h0.m1_req_n, i_h0.m0_req_n}     = req_n;
  assign {i_h16.m3_req_n, i_h16.m2_req_n, i_h16.m1_req_n, i_h16.m0_req_n} = req_n;
  assign i_h4.s_as_n  = as_n;
  assign i_h0.s_as_n  = as_n;
  assign i_h16.s_as_n = as_n;

  logic [3:0] g [3];
  logic [1:0] o [3];
  assign g[0] = {i_h4.m3_grnt_n, i_h4.m2_grnt_n, i_h4.m1_grnt_n, i_h4.m0_grnt_n};
  assign g[1] = {i_h0.m3_grnt_n, i_h0.m2_grnt_n, i_h0.m1_grnt_n, i_h0.m0_grnt_n};
  assign g[2] = {i_h16.m3_grnt_n, i_h16.m2_grnt_n, i_h16.m1_grnt_n, i_h16.m0_grnt_n};
  assign o[0] = i_h4.owner;
  assign o[1] = i_h0.owner;
  assign o[2] = i_h16.owner;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  int hmax [3] = '{4, 0, 16};
  int m_owner [3];
  int m_cnt [3];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      m_owner[k] = 0;
      m_cnt[k]   = 0;
    end
  endtask

  // Requesters other than the owner, listed in rotation order from the owner.
  task automatic model_edge();
    for (int k = 0; k < 3; k++) begin
      int  waiting [$];
      bit  own;
      own = (req_n[m_owner[k]] == 1'b0);
      for (int d = 1; d <= 3; d++) begin
        if (req_n[(m_owner[k] + d) % 4] == 1'b0) waiting.push_back((m_owner[k] + d) % 4);
      end
      if (own && hmax[k] != 0 && m_cnt[k] == hmax[k] && waiting.size() > 0 && as_n) begin
        m_owner[k] = waiting[0];
        m_cnt[k]   = 0;
      end else if (own) begin
        m_cnt[k] = (m_cnt[k] + 1 > hmax[k]) ? hmax[k] : m_cnt[k] + 1;
      end else if (waiting.size() > 0) begin
        m_owner[k] = waiting[0];
        m_cnt[k]   = 0;
      end else begin
        m_cnt[k] = 0;
      end
    end
  endtask

  task automatic check_all();
    logic [3:0] exp_g;
    for (int k = 0; k < 3; k++) begin
      exp_g = 4'hF;
      exp_g[m_owner[k]] = 1'b0;
      chk($sformatf("owner[%0d]", k), 32'(o[k]), 32'(m_owner[k]));
      chk($sformatf("grant[%0d]", k), 32'(g[k]), 32'(exp_g));
      chk($sformatf("onehot[%0d]", k), 32'($countones(~g[k])), 32'd1);
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_all();
  endtask

  initial begin
    req_n = 4'hF;
    as_n  = 1'b1;
    reset = 1'b1;
    #1 reset = 1'b0;
    model_reset();
    #2;
    check_all();
    chk("reset_owner", 32'(o[0]), 32'd0);
    chk("reset_grant", 32'(g[0]), 32'hE);
    @(negedge clk);
    reset = 1'b1;

    // Idle after reset: parked on m0.
    for (int n = 0; n < 10; n++) step();
    chk("idle_owner", 32'(o[1]), 32'd0);

    // Single request from m2, then park.
    req_n = 4'b1011;
    step();
    chk("single_owner", 32'(o[0]), 32'd2);
    chk("single_grant", 32'(g[0]), 32'b1011);
    req_n = 4'hF;
    for (int n = 0; n < 3; n++) step();
    chk("park_owner", 32'(o[2]), 32'd2);

    // Rotation: m1 owns, m0 and m3 wait, m1 releases.
    req_n = 4'b1101;
    step();
    chk("rot_m1_owner", 32'(o[2]), 32'd1);
    as_n  = 1'b0;
    req_n = 4'b0100;
    step();
    req_n = 4'b0110;
    step();
    for (int k = 0; k < 3; k++) chk($sformatf("rot_to3[%0d]", k), 32'(o[k]), 32'd3);
    req_n = 4'b1110;
    step();
    for (int k = 0; k < 3; k++) chk($sformatf("rot_to0[%0d]", k), 32'(o[k]), 32'd0);

    // Preemption with HOLD_MAX=4, bus idle.
    as_n  = 1'b1;
    req_n = 4'b1100;
    for (int n = 0; n < 4; n++) begin
      step();
      chk("pre_hold", 32'(o[0]), 32'd0);
    end
    step();
    chk("pre_switch", 32'(o[0]), 32'd1);
    chk("pre_h0_stay", 32'(o[1]), 32'd0);

    // Preemption gated by in-flight access.
    req_n = 4'b1110;
    step();
    chk("pre2_back", 32'(o[0]), 32'd0);
    as_n  = 1'b0;
    req_n = 4'b1100;
    for (int n = 0; n < 14; n++) begin
      step();
      chk("pre2_gated", 32'(o[0]), 32'd0);
    end
    as_n = 1'b1;
    step();
    chk("pre2_switch", 32'(o[0]), 32'd1);

    // Preemption disabled: m0 keeps the bus on the HOLD_MAX=0 instance.
    for (int n = 0; n < 100; n++) begin
      as_n = 1'($urandom_range(1));
      step();
      chk("nopre_hold", 32'(o[1]), 32'd0);
    end
    as_n  = 1'b1;
    req_n = 4'b1101;
    step();
    chk("nopre_release", 32'(o[1]), 32'd1);

    // Asynchronous reset mid-transfer with m3 owning.
    req_n = 4'b0111;
    step();
    chk("mid_owner3", 32'(o[1]), 32'd3);
    as_n = 1'b0;
    #2 reset = 1'b0;
    model_reset();
    #1;
    check_all();
    chk("mid_rst_m0", 32'(g[0][0]), 32'd0);
    chk("mid_rst_m3", 32'(g[0][3]), 32'd1);
    #1 reset = 1'b1;
    req_n = 4'hF;
    as_n  = 1'b1;
    step();

    // Random traffic with sticky requests.
    for (int n = 0; n < 600; n++) begin
      for (int b = 0; b < 4; b++) begin
        if ($urandom_range(3) == 0) req_n[b] = ~req_n[b];
      end
      as_n = ($urandom_range(2) != 0);
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/bus_arbiter.md
# bus_arbiter

Round-robin arbiter for the four bus masters. It owns the `mN_grnt_n` signals that select which master's address, control and write data the bus master multiplexer drives onto the shared bus. Exactly one master holds the grant at all times; when no master requests, the grant stays parked on the last owner. An optional hold limit stops a master from monopolising the bus, and it only switches owners when no access is in flight.

## Interface
Parameters:
- `HOLD_MAX`, default 16: number of consecutive owned cycles before the owner can be preempted. Legal range is 0–255. A value of 0 disables preemption.

Ports:
- `clk`  input  1  system clock; all state changes on the rising edge.
- `reset`  input  1  asynchronous, active-low reset.
- `m0_req_n` … `m3_req_n`  input  1 each  bus request from master N, active-low.
- `s_as_n`  input  1  shared-bus address strobe, active-low. Low means an access is in flight.
- `m0_grnt_n` … `m3_grnt_n`  output  1 each  bus grant to master N, active-low, registered. Always one-hot: exactly one is low.
- `owner`  output  2  index of the current grant holder, registered.

## Operation
- State:
  - `owner` register, 2 bits.
  - `hold_cnt` register, 8 bits, saturating at `HOLD_MAX`.
  - Grant outputs are registered and decoded from the next-owner value, so they always equal the one-hot active-low decode of `owner`.
- Definitions:
  - `own_req` = the current owner's `req_n` is low.
  - `other_req` = any non-owner `req_n` is low.
  - `rr_next` = the first requesting master scanning owner+1, owner+2, owner+3 (mod 4). The current owner is never selected by the scan.
- Each rising edge, evaluated in priority order:
  1. **Preempt:** `own_req` AND `HOLD_MAX != 0` AND `hold_cnt == HOLD_MAX` AND `other_req` AND `s_as_n == 1`. Result: owner ← `rr_next`, `hold_cnt` ← 0.
  2. **Hold:** `own_req`. Result: owner unchanged, `hold_cnt` ← min(`hold_cnt`+1, `HOLD_MAX`).
  3. **Handover:** owner released AND `other_req`. Result: owner ← `rr_next`, `hold_cnt` ← 0. This does not wait on `s_as_n`, because a master that has released its request has ended its access.
  4. **Park:** no requests at all. Result: owner unchanged, `hold_cnt` ← 0.
- When preemption is eligible but `s_as_n == 0`, the arbiter holds and `hold_cnt` stays saturated. The switch happens on the first edge at which `s_as_n == 1`, provided another request is still pending.
- Simultaneous requests are resolved purely by the rotation order from the current owner; there is no fixed priority.
- A request and a release by the owner in the same cycle follow rule 3.
- Reset, applied asynchronously and at any time including mid-transfer:
  - `owner` = 0, `hold_cnt` = 0.
  - `m0_grnt_n` = 0; `m1_grnt_n`, `m2_grnt_n`, `m3_grnt_n` = 1.
  - Any in-flight transfer is abandoned; the arbiter does not wait for `s_as_n`.
- Deassertion of `reset` is synchronised externally. The first rising edge after release applies the rules above.

## Timing
- Request to grant latency is 1 clock:
  - A `req_n` sampled low at edge k, with the bus free or released, gives a grant that is low after edge k.
  - `owner` changes at the same edge.
- Release to new grant is 1 clock. The old grant rises at the same edge the new grant falls, so there is no cycle with zero grants or two grants.
- Preemption happens at the earliest on the edge after the owner has held for `HOLD_MAX` counted cycles with a competitor pending, gated by `s_as_n == 1`.
- Inputs have no combinational path to outputs.
- Masters must keep `req_n` low until they deassert `as_n` for their final access. The arbiter does not check this.

## Test plan
- **Reset:** assert `reset` = 0 with all `req_n` = 1.
  - Required: `m0_grnt_n` = 0, others = 1, `owner` = 0.
  - After release, with no requests for 10 cycles, the grant stays on m0.
- **Single request:** drive `m2_req_n` = 0 from owner 0.
  - Required: one edge later `m2_grnt_n` = 0, `m0_grnt_n` = 1, `owner` = 2.
  - Drop `m2_req_n`: `owner` stays 2 (parked).
- **Rotation:** owner = 1 holding; `m0_req_n` = 0 and `m3_req_n` = 0; then m1 releases.
  - Required: next edge `owner` = 3.
  - When m3 releases: `owner` = 0.
- **Preemption** (`HOLD_MAX` = 4): m0 owns and keeps requesting; `m1_req_n` = 0; `s_as_n` = 1.
  - Required: after 4 hold cycles, the next edge gives `owner` = 1.
  - Repeat with `s_as_n` held at 0 for 10 cycles: no switch; the switch occurs one edge after `s_as_n` returns to 1.
- **Preemption disabled** (`HOLD_MAX` = 0): m0 holds for 100 cycles with `m1_req_n` = 0.
  - Required: `owner` stays 0 throughout; `owner` = 1 one edge after m0 releases.
- **Reset mid-operation:** with `owner` = 3 and `s_as_n` = 0, pulse `reset` low between clock edges.
  - Required: immediately `m0_grnt_n` = 0, `m3_grnt_n` = 1, `owner` = 0.
  - The one-hot grant property is checked on every cycle of every test.
